csi2_tpg_timing: RTL
====================

// Module: csi2_tpg_timing
// PURPOSE
// - Test-pattern source directly upstream of the p2b pixel-to-byte stage.
// - Replaces the camera parallel bus with a synthetic one: generates fv/lv/dvalid timing and
//   multi-lane pixel data, so the CSI-2 TX path can be brought up without a sensor.
// - Outputs connect 1:1 to the top-level fv_i/lv_i/dvalid_i/pixdata_i nets.
// PARAMETERS
// - PIX_WIDTH     10    bits per pixel
// - NUM_PIX_LANE  2     pixels per clock (1,2,4); H_ACTIVE_PIX must be a multiple of it
// - H_ACTIVE_PIX  1280  active pixels per line; must be a multiple of 8*NUM_PIX_LANE
// - H_BLANK       64    clocks with lv low after each line
// - V_ACTIVE      720   active lines per frame
// - V_LEAD        16    clocks from fv rise to first lv rise
// - V_TRAIL       16    clocks from last line's blank end to fv fall
// - V_BLANK       1000  clocks with fv low between frames (>=1)
// PORTS
// - pix_clk_i      in   1                         pixel clock; sole clock
// - reset_i        in   1                         synchronous reset, active-high
// - enable_i       in   1                         run frames while high
// - pattern_sel_i  in   2                         0 solid, 1 ramp, 2 colour bars, 3 checker
// - fv_o           out  1                         frame valid
// - lv_o           out  1                         line valid
// - dvalid_o       out  1                         data valid; identical to lv_o
// - pixdata_o      out  PIX_WIDTH*NUM_PIX_LANE    lane k at [k*PIX_WIDTH +: PIX_WIDTH]
// - frame_start_o  out  1                         1-clock pulse on the fv rising cycle
// - frame_cnt_o    out  16                        completed frames; wraps 0xFFFF->0
// BEHAVIOUR
// - All outputs registered. Reset value of every output is 0; state is IDLE.
// - Reset asserted mid-frame: all outputs 0 on the next edge. No partial line or fv fall completes.
// - Definition: HB = H_ACTIVE_PIX/NUM_PIX_LANE active beats per line.
// - FSM: IDLE -> LEAD -> ACTIVE -> HBLANK -> (ACTIVE | TRAIL) -> VBLANK -> (LEAD | IDLE).
//   - IDLE: fv=lv=0. When enable_i=1, go to LEAD. fv_o rises one clock after enable_i is sampled high.
//   - LEAD: fv=1, lv=0 for V_LEAD clocks.
//   - ACTIVE: fv=lv=dvalid=1 for HB clocks. Pixel x = beat*NUM_PIX_LANE + k.
//   - HBLANK: lv=0, pixdata=0 for H_BLANK clocks. Next state is ACTIVE, or TRAIL after line V_ACTIVE-1.
//   - TRAIL: fv=1 for V_TRAIL clocks.
//   - VBLANK: fv=0 for V_BLANK clocks. frame_cnt_o increments on the first VBLANK clock.
//     At VBLANK end: go to LEAD if enable_i=1, else IDLE.
// - Frame length = V_LEAD + V_ACTIVE*(HB+H_BLANK) + V_TRAIL + V_BLANK clocks.
// - enable_i falling mid-frame: the current frame completes, then the FSM goes to IDLE.
// - pattern_sel_i is latched on the IDLE/VBLANK -> LEAD transition. Mid-frame changes are ignored.
// - Pattern values (M = 2^PIX_WIDTH-1; x = column, y = line, both from 0):
//   - 0 solid: 2^(PIX_WIDTH-1) on every pixel.
//   - 1 ramp: x mod 2^PIX_WIDTH.
//   - 2 bars: b = x/(H_ACTIVE_PIX/8); value {b[2:0], (PIX_WIDTH-3){0}}.
//   - 3 checker: (x[4]^y[4]) ? M : 0.
// - pixdata_o is 0 whenever lv_o=0.
// - Counters (beat, line, phase) are sized by $clog2 of their maximum.
// - Simultaneous events: the terminal count of one phase and entry to the next occur on the same edge.
//   There are no idle gap clocks.
// CONFIGURATION
// - TPG_FRAME_STAMP_EN defined:
//   - Lane 0 of beat 0 on line 0 carries frame_cnt_o[PIX_WIDTH-1:0] instead of the pattern value.
//   - All other pixels are unchanged. Used by the receiver to detect dropped frames.
// - TPG_FRAME_STAMP_EN undefined: pure pattern output, no stamp logic.
// TESTING (PIX_WIDTH=10, NUM_PIX_LANE=2, H_ACTIVE_PIX=16, H_BLANK=4, V_ACTIVE=4,
//          V_LEAD=2, V_TRAIL=2, V_BLANK=3; HB=8, frame=55 clocks)
// - Timing: reset, then enable_i=1.
//   -> fv high 52 clocks, low 3. Four lv pulses of 8 clocks, 4 clocks apart.
//   -> First lv rises 2 clocks after fv. frame_start_o pulses once per 55 clocks.
// - Ramp: sel=1 -> line 0 beats carry {x1,x0} = {1,0}, {3,2}, ... {15,14}. pixdata=0 during HBLANK.
// - Bars/checker: sel=2 -> beat 3 lane 0 (x=6) = 0x180. sel=3 -> all pixels 0 (x,y < 16).
// - Latch: change sel 0->1 mid-frame -> current frame stays solid 0x200; next frame is ramp.
// - Stop/reset: drop enable_i at line 2 -> frame completes, then IDLE with frame_cnt_o=1.
//   Assert reset_i mid-ACTIVE -> all outputs 0 on the next clock.
// - Stamp (TPG_FRAME_STAMP_EN, sel=0): first pixel of frame n = n. All other pixels = 0x200.
//   Force frame_cnt_o=0xFFFF -> next value is 0x0000.

Source files
------------

// File: rtl/csi2_tpg_timing.sv
// csi2_tpg_timing: synthetic fv/lv/dvalid timing and multi-lane test-pattern source for the CSI-2 TX path
// Define TPG_FRAME_STAMP_EN to stamp frame_cnt_o into the first pixel of each frame.
module csi2_tpg_timing #(
  parameter int PIX_WIDTH    = 10,
  parameter int NUM_PIX_LANE = 2,
  parameter int H_ACTIVE_PIX = 1280,
  parameter int H_BLANK      = 64,
  parameter int V_ACTIVE     = 720,
  parameter int V_LEAD       = 16,
  parameter int V_TRAIL      = 16,
  parameter int V_BLANK      = 1000
) (
  input  logic                              pix_clk_i,
  input  logic                              reset_i,
  input  logic                              enable_i,
  input  logic [1:0]                        pattern_sel_i,
  output logic                              fv_o,
  output logic                              lv_o,
  output logic                              dvalid_o,
  output logic [PIX_WIDTH*NUM_PIX_LANE-1:0] pixdata_o,
  output logic                              frame_start_o,
  output logic [15:0]                       frame_cnt_o
);
  localparam int HB   = H_ACTIVE_PIX / NUM_PIX_LANE;
  localparam int M1   = V_LEAD > HB ? V_LEAD : HB;
  localparam int M2   = M1 > H_BLANK ? M1 : H_BLANK;
  localparam int M3   = M2 > V_TRAIL ? M2 : V_TRAIL;
  localparam int PMAX = M3 > V_BLANK ? M3 : V_BLANK;
  localparam int CW   = PMAX > 1 ? $clog2(PMAX) : 1;
  localparam int LW   = V_ACTIVE > 1 ? $clog2(V_ACTIVE) : 1;
  typedef enum logic [2:0] {IDLE, LEAD, ACTIVE, HBLANK, TRAIL, VBLANK} state_t;
  state_t state, nstate;
  logic [CW-1:0] cnt, ncnt;
  logic [LW-1:0] line, nline;
  logic [1:0] pat;
  logic [PIX_WIDTH*NUM_PIX_LANE-1:0] npix;
  logic start;
  function automatic logic [PIX_WIDTH-1:0] pix_val(input logic [31:0] x, input logic [31:0] y,
                                                   input logic [1:0] p);
    logic [31:0] b;
    b = x / 32'(H_ACTIVE_PIX / 8);
    return p == 2'd0 ? PIX_WIDTH'(1 << (PIX_WIDTH - 1)) :
           p == 2'd1 ? x[PIX_WIDTH-1:0] :
           p == 2'd2 ? {b[2:0], {(PIX_WIDTH-3){1'b0}}} :
                       {PIX_WIDTH{x[4] ^ y[4]}};
  endfunction
  always_comb begin
    nstate = state;
    ncnt = cnt + 1'b1;
    nline = line;
    case (state)
      IDLE: begin
        ncnt = '0;
        nstate = enable_i ? LEAD : IDLE;
      end
      LEAD: if (cnt == CW'(V_LEAD - 1)) begin
        nstate = ACTIVE;
        ncnt = '0;
        nline = '0;
      end
      ACTIVE: if (cnt == CW'(HB - 1)) begin
        nstate = HBLANK;
        ncnt = '0;
      end
      HBLANK: if (cnt == CW'(H_BLANK - 1)) begin
        nstate = line == LW'(V_ACTIVE - 1) ? TRAIL : ACTIVE;
        nline = line + 1'b1;
        ncnt = '0;
      end
      TRAIL: if (cnt == CW'(V_TRAIL - 1)) begin
        nstate = VBLANK;
        ncnt = '0;
      end
      VBLANK: if (cnt == CW'(V_BLANK - 1)) begin
        nstate = enable_i ? LEAD : IDLE;
        ncnt = '0;
      end
      default: nstate = IDLE;
    endcase
  end
  // Pixels are computed for the beat being entered so pixdata_o lines up with lv_o.
  always_comb begin
    npix = '0;
    for (int k = 0; k < NUM_PIX_LANE; k++)
      npix[k*PIX_WIDTH +: PIX_WIDTH] = pix_val(32'(ncnt) * 32'(NUM_PIX_LANE) + 32'(k), 32'(nline), pat);
`ifdef TPG_FRAME_STAMP_EN
    if (nline == '0 && ncnt == '0) npix[PIX_WIDTH-1:0] = frame_cnt_o[PIX_WIDTH-1:0];
`else
`endif
  end
  assign start = nstate == LEAD && state != LEAD;
  assign dvalid_o = lv_o;
  always_ff @(posedge pix_clk_i) begin
    if (reset_i) begin
      state <= IDLE;
      cnt <= '0;
      line <= '0;
      pat <= '0;
      fv_o <= 1'b0;
      lv_o <= 1'b0;
      pixdata_o <= '0;
      frame_start_o <= 1'b0;
      frame_cnt_o <= '0;
    end else begin
      state <= nstate;
      cnt <= ncnt;
      line <= nline;
      if (start) pat <= pattern_sel_i;
      fv_o <= nstate inside {LEAD, ACTIVE, HBLANK, TRAIL};
      lv_o <= nstate == ACTIVE;
      pixdata_o <= nstate == ACTIVE ? npix : '0;
      frame_start_o <= start;
      if (nstate == VBLANK && state == TRAIL) frame_cnt_o <= frame_cnt_o + 1'b1;
    end
  end
endmodule
